sin_lut_arbiter: RTL

Shares one sine look-up ROM (rom_256x8b, 256×8, one-cycle registered-address read) between several phase-accumulator requesters, such as the I/Q NCO branches and the loop-monitor tap in the carrier-recovery chain. It grants at most one ROM read per cycle using round-robin priority. It tags each in-flight read so the data returns to the requester that issued it, and it counts contention cycles for debug.

---
 rtl/nco_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/sin_lut_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Definitions shared by the carrier-recovery NCO blocks and the
// clients of the sine look-up ROM.
package nco_pkg;

    localparam int STALL_CNT_W = 16;

    typedef logic [7:0] lut_addr_t;

    // Index of the set bit in a one-hot vector of up to eight requesters.
    // An all-zero vector gives index 0.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: grants the first active request found at
// or after ptr, wrapping modulo NUM_REQ. Purely combinational.
module rr_arbiter
    import nco_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    logic       found;
    logic [7:0] gnt_pad;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
                gnt[(int'(ptr) + i) % NUM_REQ] = 1'b1;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_pad                = '0;
        gnt_pad[NUM_REQ-1:0]   = gnt;
        gnt_idx                = PTR_W'(onehot_to_idx(gnt_pad));
        gnt_valid              = |gnt;
    end

endmodule

// File: rtl/sin_lut_arbiter.sv
// Shares one sine ROM among NUM_REQ phase accumulators: one round-robin
// grant per cycle, response tags aligned to the ROM latency, stall counter.
module sin_lut_arbiter
    import nco_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [ADDR_WIDTH-1:0]         rom_addr_o,
    input  logic [DATA_WIDTH-1:0]         rom_q_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [STALL_CNT_W-1:0]        stall_cnt_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0]  addr_hold_q, addr_hold_d;
    logic [NUM_REQ-1:0]     tag_q [ROM_LATENCY];
    logic [NUM_REQ-1:0]     tag_d [ROM_LATENCY];
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [PTR_W-1:0]       arb_idx;
    logic                   arb_valid;
    logic                   grant_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req       (req_i),
        .ptr       (rr_ptr_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // Grants are suppressed while reset is held so nothing enters the tag pipe.
    always_comb begin
        grant_valid = reset_n && arb_valid;
        gnt_o       = grant_valid ? arb_gnt : '0;
        rom_addr_o  = grant_valid ? addr_i[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH]
                                  : addr_hold_q;
        addr_hold_d = rom_addr_o;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
        end
    end

    always_comb begin
        tag_d[0] = gnt_o;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ($countones(req_i) >= 2 && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            addr_hold_q <= '0;
            stall_cnt_q <= '0;
            // NOTE: every tag stage is reset, which is what discards reads
            // still in flight when reset arrives.
            for (int i = 0; i < ROM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            addr_hold_q <= addr_hold_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign rsp_valid_o = tag_q[ROM_LATENCY-1];
    assign rsp_data_o  = rom_q_i;
    assign stall_cnt_o = stall_cnt_q;

endmodule
